mem_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch requester and the data-access (load/store) requester in the pipeline. Each requester sees the same start/ready/addr/data/valid handshake the memory presents, so the fetch stage connects unchanged. Requests are latched, arbitrated, issued one at a time to memory, and the response is routed back to the owner.

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory request port between the instruction-fetch
// requester (i_*) and the data load/store requester (d_*).
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN. When defined, a tie goes to the port
// that was not granted last; when undefined, the data port always wins a tie.
//
// Handshake (all ports): a start pulse is accepted only in a cycle where the matching
// ready is 1, and the request fields are sampled in that same cycle. Completion is a
// one-cycle valid pulse, and ready rises again the cycle after it. Toward memory,
// mem_start is a one-cycle pulse issued only after mem_ready was seen at 1, and
// mem_addr/mem_wen/mem_wdata stay stable from mem_start until mem_data_valid.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-fetch requester
    input  logic                  i_start,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_data_valid,
    // data requester
    input  logic                  d_start,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_wen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_data_valid,
    // memory
    output logic                  mem_start,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_data_valid,
    // debug: 0 = IDLE, 1 = WAIT (a memory access is in service)
    output logic                  dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    state_t                state_q, state_d;
    grant_t                grant_q, grant_d;

    logic                  i_pend_q, i_pend_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic                  d_pend_q, d_pend_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic                  d_wen_q, d_wen_d;
    logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;

    logic                  mem_start_q, mem_start_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;

    logic                  i_accept;
    logic                  d_accept;
    logic                  pick_data;

    // State, latched requests, memory request fields and ready flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_FETCH;
            i_pend_q    <= 1'b0;
            i_addr_q    <= '0;
            d_pend_q    <= 1'b0;
            d_addr_q    <= '0;
            d_wen_q     <= 1'b0;
            d_wdata_q   <= '0;
            mem_start_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b1;
            d_ready_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            i_pend_q    <= i_pend_d;
            i_addr_q    <= i_addr_d;
            d_pend_q    <= d_pend_d;
            d_addr_q    <= d_addr_d;
            d_wen_q     <= d_wen_d;
            d_wdata_q   <= d_wdata_d;
            mem_start_q <= mem_start_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    // Accept requests, arbitrate in IDLE, wait for completion in WAIT.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        i_pend_d    = i_pend_q;
        i_addr_d    = i_addr_q;
        d_pend_d    = d_pend_q;
        d_addr_d    = d_addr_q;
        d_wen_d     = d_wen_q;
        d_wdata_d   = d_wdata_q;
        mem_start_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        pick_data   = 1'b0;

        // A start arriving this cycle counts as pending right away, so the
        // earliest mem_start is the cycle right after the start is accepted.
        i_accept = i_start & i_ready_q;
        d_accept = d_start & d_ready_q;
        if (i_accept) begin
            i_pend_d = 1'b1;
            i_addr_d = i_addr;
        end
        if (d_accept) begin
            d_pend_d  = 1'b1;
            d_addr_d  = d_addr;
            d_wen_d   = d_wen;
            d_wdata_d = d_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if ((i_pend_d | d_pend_d) & mem_ready) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (i_pend_d & d_pend_d) begin
                        pick_data = (grant_q == GNT_FETCH);
                    end else begin
                        pick_data = d_pend_d;
                    end
`else
                    pick_data = d_pend_d;
`endif
                    state_d     = ST_WAIT;
                    mem_start_d = 1'b1;
                    if (pick_data) begin
                        grant_d     = GNT_DATA;
                        d_pend_d    = 1'b0;
                        mem_addr_d  = d_addr_d;
                        mem_wen_d   = d_wen_d;
                        mem_wdata_d = d_wdata_d;
                    end else begin
                        // Fetch never writes memory.
                        grant_d     = GNT_FETCH;
                        i_pend_d    = 1'b0;
                        mem_addr_d  = i_addr_d;
                        mem_wen_d   = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_data_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A port is ready only with nothing pending and nothing in service.
        i_ready_d = ~i_pend_d & ~((state_d == ST_WAIT) & (grant_d == GNT_FETCH));
        d_ready_d = ~d_pend_d & ~((state_d == ST_WAIT) & (grant_d == GNT_DATA));
    end

    // Responses go straight through to the granted port with no added latency;
    // a valid seen outside WAIT belongs to nobody and is dropped.
    assign i_data       = mem_data;
    assign d_data       = mem_data;
    assign i_data_valid = mem_data_valid & (state_q == ST_WAIT) & (grant_q == GNT_FETCH);
    assign d_data_valid = mem_data_valid & (state_q == ST_WAIT) & (grant_q == GNT_DATA);

    assign i_ready      = i_ready_q;
    assign d_ready      = d_ready_q;
    assign mem_start    = mem_start_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wen      = mem_wen_q;
    assign mem_wdata    = mem_wdata_q;
    assign dbg_state_o  = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: directed steps from the test plan, then a randomized
// phase checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_ready, i_data_valid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          d_start, d_ready, d_wen, d_data_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_data;
    logic          mem_start, mem_ready, mem_wen, mem_data_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_data;
    logic          dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard of expected memory requests: {wen, addr, wdata}.
    logic [AW+DW:0] exp_q[$];

    // Reference model state (per-port outstanding/pending, memory busy owner).
    bit            mi_out, mi_pend, md_out, md_pend;
    bit            m_busy, m_owner_d, m_last_d, m_start, pick_d;
    bit            exp_iv, exp_dv;
    logic [AW-1:0] mi_addr, md_addr, cur_addr;
    logic          md_wen, cur_wen;
    logic [DW-1:0] md_wdata, cur_wdata;
    logic [AW+DW:0] req;
    int            m_lat;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_ready(i_ready), .i_addr(i_addr),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .d_start(d_start), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_data(d_data), .d_data_valid(d_data_valid),
        .mem_start(mem_start), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_data(mem_data),
        .mem_data_valid(mem_data_valid), .dbg_state_o(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move just past the next rising edge and drop all one-cycle pulses.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        i_start        = 1'b0;
        d_start        = 1'b0;
        mem_data_valid = 1'b0;
    endtask

    task automatic model_reset();
        mi_out = 0; mi_pend = 0; md_out = 0; md_pend = 0;
        m_busy = 0; m_owner_d = 0; m_last_d = 0; m_start = 0;
        m_lat = 0;
        cur_addr = '0; cur_wen = 1'b0; cur_wdata = '0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        i_start = 0; i_addr = '0;
        d_start = 0; d_addr = '0; d_wen = 0; d_wdata = '0;
        mem_ready = 1'b1; mem_data = '0; mem_data_valid = 1'b0;

        // ---- reset values ----
        @(negedge clk);
        check("rst_i_ready", i_ready, 1);
        check("rst_d_ready", d_ready, 1);
        check("rst_mem_start", mem_start, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_valid", i_data_valid, 0);
        check("rst_d_valid", d_data_valid, 0);
        check("rst_state", dbg_state, 0);
        next_cycle();
        rst = 1'b0;

        // ---- single fetch, memory answers 3 cycles after mem_start ----
        next_cycle();
        i_start = 1; i_addr = 32'h0000_0010;
        @(negedge clk);
        check("f_ready_before", i_ready, 1);
        next_cycle();
        @(negedge clk);
        check("f_mem_start", mem_start, 1);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_mem_wen", mem_wen, 0);
        check("f_i_ready_busy", i_ready, 0);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            check("f_start_one_cycle", mem_start, 0);
            check("f_addr_hold", mem_addr, 32'h10);
        end
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h0000_0033;
        i_start = 1; i_addr = 32'h77;  // must be ignored: i_ready is 0 here
        @(negedge clk);
        check("f_i_valid", i_data_valid, 1);
        check("f_i_data", i_data, 32'h33);
        check("f_d_valid_quiet", d_data_valid, 0);
        next_cycle();
        @(negedge clk);
        check("f_i_ready_back", i_ready, 1);
        check("f_i_valid_pulse", i_data_valid, 0);
        check("f_no_restart", mem_start, 0);
        next_cycle();
        @(negedge clk);
        check("f_start_in_valid_ignored", mem_start, 0);

        // ---- data write ----
        next_cycle();
        d_start = 1; d_wen = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        next_cycle();
        d_wen = 0; d_addr = '0; d_wdata = 32'h1234_5678;
        @(negedge clk);
        check("w_mem_start", mem_start, 1);
        check("w_mem_addr", mem_addr, 32'h100);
        check("w_mem_wen", mem_wen, 1);
        check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("w_d_ready_busy", d_ready, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("w_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        check("w_wen_hold", mem_wen, 1);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h0000_ABCD;
        @(negedge clk);
        check("w_d_valid", d_data_valid, 1);
        check("w_i_valid_quiet", i_data_valid, 0);
        next_cycle();
        @(negedge clk);
        check("w_d_ready_back", d_ready, 1);

        // ---- first tie: data wins in both builds, fetch follows ----
        next_cycle();
        i_start = 1; i_addr = 32'h200;
        d_start = 1; d_addr = 32'h300; d_wen = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("t1_mem_start", mem_start, 1);
        check("t1_first_addr", mem_addr, 32'h300);
        check("t1_first_wen", mem_wen, 0);
        check("t1_i_ready", i_ready, 0);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h55;
        @(negedge clk);
        check("t1_d_valid", d_data_valid, 1);
        check("t1_d_data", d_data, 32'h55);
        check("t1_i_valid_quiet", i_data_valid, 0);
        next_cycle();
        @(negedge clk);
        check("t1_no_b2b_start", mem_start, 0);
        check("t1_d_ready", d_ready, 1);
        next_cycle();
        @(negedge clk);
        check("t1_second_start", mem_start, 1);
        check("t1_second_addr", mem_addr, 32'h200);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h66;
        @(negedge clk);
        check("t1_i_valid", i_data_valid, 1);
        check("t1_i_data", i_data, 32'h66);
        check("t1_d_valid_quiet", d_data_valid, 0);
        next_cycle();

        // ---- solo data read, then a second tie (last grant = data) ----
        next_cycle();
        d_start = 1; d_addr = 32'h500; d_wen = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("t2_solo_addr", mem_addr, 32'h500);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h1;
        @(negedge clk);
        check("t2_solo_valid", d_data_valid, 1);
        next_cycle();
        next_cycle();
        i_start = 1; i_addr = 32'h600;
        d_start = 1; d_addr = 32'h700; d_wen = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("t2_tie_winner", mem_addr, RR ? 32'h600 : 32'h700);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h77;
        @(negedge clk);
        check("t2_first_i_valid", i_data_valid, RR ? 1 : 0);
        check("t2_first_d_valid", d_data_valid, RR ? 0 : 1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("t2_second_addr", mem_addr, RR ? 32'h700 : 32'h600);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h88;
        @(negedge clk);
        check("t2_second_i_valid", i_data_valid, RR ? 0 : 1);
        next_cycle();

        // ---- backpressure: mem_ready low, fetch re-pulsed while busy ----
        next_cycle();
        mem_ready = 0; i_start = 1; i_addr = 32'h400;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k == 2) begin
                i_start = 1; i_addr = 32'h999;
            end
            @(negedge clk);
            check("bp_no_start", mem_start, 0);
            check("bp_i_ready", i_ready, 0);
        end
        next_cycle();
        mem_ready = 1;
        @(negedge clk);
        check("bp_still_no_start", mem_start, 0);
        next_cycle();
        @(negedge clk);
        check("bp_issue", mem_start, 1);
        check("bp_addr", mem_addr, 32'h400);
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h44;
        @(negedge clk);
        check("bp_i_valid", i_data_valid, 1);
        check("bp_i_data", i_data, 32'h44);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            check("bp_single_access", mem_start, 0);
        end

        // ---- reset while a fetch is in service ----
        next_cycle();
        i_start = 1; i_addr = 32'h800;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rw_issue", mem_start, 1);
        next_cycle();
        rst = 1;
        @(negedge clk);
        check("rw_i_ready", i_ready, 1);
        check("rw_d_ready", d_ready, 1);
        check("rw_mem_start", mem_start, 0);
        check("rw_state", dbg_state, 0);
        next_cycle();
        rst = 0; mem_data_valid = 1; mem_data = 32'hBAD;
        @(negedge clk);
        check("rw_late_i_valid", i_data_valid, 0);
        check("rw_late_d_valid", d_data_valid, 0);
        next_cycle();
        @(negedge clk);
        check("rw_no_start", mem_start, 0);

        // ---- stray valid in IDLE ----
        next_cycle();
        mem_data_valid = 1; mem_data = 32'h99;
        @(negedge clk);
        check("stray_i_valid", i_data_valid, 0);
        check("stray_d_valid", d_data_valid, 0);

        // ---- randomized traffic against the model ----
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            next_cycle();
            i_start   = ($urandom_range(0, 3) == 0);
            i_addr    = $urandom;
            d_start   = ($urandom_range(0, 3) == 0);
            d_addr    = $urandom;
            d_wen     = 1'($urandom_range(0, 1));
            d_wdata   = $urandom;
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_busy) begin
                if (m_lat == 0) begin
                    mem_data_valid = 1; mem_data = $urandom;
                end else begin
                    m_lat--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                mem_data_valid = 1; mem_data = $urandom;
            end
            @(negedge clk);

            check("rnd_i_ready", i_ready, !mi_out);
            check("rnd_d_ready", d_ready, !md_out);
            check("rnd_mem_start", mem_start, m_start);
            check("rnd_state", dbg_state, m_busy);
            if (m_start) begin
                req = exp_q.pop_front();
                check("rnd_req_wen", mem_wen, req[AW+DW]);
                check("rnd_req_addr", mem_addr, req[AW+DW-1:DW]);
                check("rnd_req_wdata", mem_wdata, req[DW-1:0]);
            end
            if (m_busy) begin
                check("rnd_addr_hold", mem_addr, cur_addr);
                check("rnd_wen_hold", mem_wen, cur_wen);
            end
            exp_iv = mem_data_valid && m_busy && !m_owner_d;
            exp_dv = mem_data_valid && m_busy && m_owner_d;
            check("rnd_i_valid", i_data_valid, exp_iv);
            check("rnd_d_valid", d_data_valid, exp_dv);
            if (exp_iv) check("rnd_i_data", i_data, mem_data);
            if (exp_dv) check("rnd_d_data", d_data, mem_data);

            // What the coming edge does, by the arbitration rules.
            m_start = 0;
            if (i_start && !mi_out) begin
                mi_out = 1; mi_pend = 1; mi_addr = i_addr;
            end
            if (d_start && !md_out) begin
                md_out = 1; md_pend = 1;
                md_addr = d_addr; md_wen = d_wen; md_wdata = d_wdata;
            end
            if (m_busy) begin
                if (mem_data_valid) begin
                    m_busy = 0;
                    if (m_owner_d) md_out = 0;
                    else mi_out = 0;
                end
            end else if ((mi_pend || md_pend) && mem_ready) begin
                if (mi_pend && md_pend) pick_d = RR ? !m_last_d : 1'b1;
                else pick_d = md_pend;
                m_busy = 1; m_start = 1;
                m_owner_d = pick_d; m_last_d = pick_d;
                m_lat = $urandom_range(0, 3);
                if (pick_d) begin
                    md_pend = 0;
                    cur_addr = md_addr; cur_wen = md_wen; cur_wdata = md_wdata;
                end else begin
                    mi_pend = 0;
                    cur_addr = mi_addr; cur_wen = 1'b0; cur_wdata = '0;
                end
                exp_q.push_back({cur_wen, cur_addr, cur_wdata});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
